// File: rtl/tanh_pkg.sv
// Shared constants for the tanh MAC datapath: default widths, the
// piecewise-linear tanh clamp points and the 8-segment base/slope tables.
package tanh_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;
    localparam int ACC_W  = 48;
    localparam int ADDR_W = 12;

    // |x| at or above 4.0 (Q4.12) saturates to the tanh asymptote value.
    localparam int PWL_CLAMP = 16384;
    localparam int Y_CLAMP   = 4093;

    // Segment i covers |x| in [0.5*i, 0.5*(i+1)); y = base + slope*dx/4096.
    localparam logic [11:0] PWL_BASE [8] = '{
        12'd0, 12'd1893, 12'd3119, 12'd3707, 12'd3949, 12'd4041, 12'd4076, 12'd4089
    };
    localparam logic [11:0] PWL_SLOPE [8] = '{
        12'd3786, 12'd2452, 12'd1176, 12'd484, 12'd184, 12'd70, 12'd26, 12'd8
    };

endpackage

// File: rtl/tanh_pwl.sv
// Three-stage piecewise-linear tanh on a Q4.12 operand with a valid/address
// sideband. Fully pipelined, no stall; usable as a standalone activation.
module tanh_pwl
    import tanh_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic [AW-1:0]            addr_i,
    output logic                     valid_o,
    output logic signed [DATA_W-1:0] y_o,
    output logic [AW-1:0]            addr_o
);

    logic [DATA_W-1:0] ax_d;
    logic              clamp_d;

    logic              t1_valid_q, t1_sign_q, t1_clamp_q;
    logic [2:0]        t1_seg_q;
    logic [10:0]       t1_dx_q;
    logic [AW-1:0]     t1_addr_q;

    logic [22:0]       slope_prod_d;
    logic [12:0]       y_d;

    logic              t2_valid_q, t2_sign_q;
    logic [12:0]       t2_y_q;
    logic [AW-1:0]     t2_addr_q;

    logic [DATA_W-1:0] y_mag_d;

    // T1 magnitude: -32768 negates to 32768, which the unsigned compare
    // below sees as >= 4.0, so it falls into the clamp with no special case.
    // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        ax_d    = x_i[DATA_W-1] ? (~x_i + 1'b1) : x_i;
        clamp_d = (ax_d >= DATA_W'(PWL_CLAMP));
    end

    // T1 register: sign, clamp decision, segment index and in-segment offset.
    // NOTE: clocked state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            t1_valid_q <= 1'b0;
            t1_sign_q  <= 1'b0;
            t1_clamp_q <= 1'b0;
            t1_seg_q   <= '0;
            t1_dx_q    <= '0;
            t1_addr_q  <= '0;
        end else begin
            t1_valid_q <= valid_i;
            t1_sign_q  <= x_i[DATA_W-1];
            t1_clamp_q <= clamp_d;
            t1_seg_q   <= ax_d[13:11];
            t1_dx_q    <= ax_d[10:0];
            t1_addr_q  <= addr_i;
        end
    end

    // T2 interpolation: base plus scaled slope, or the asymptote when clamped.
    always_comb begin
        slope_prod_d = PWL_SLOPE[t1_seg_q] * t1_dx_q;
        y_d          = {1'b0, PWL_BASE[t1_seg_q]} + {2'b00, slope_prod_d[22:12]};
        if (t1_clamp_q) begin
            y_d = 13'(Y_CLAMP);
        end
    end

    // T2 register: unsigned magnitude result plus sideband.
    always_ff @(posedge clock) begin
        if (reset) begin
            t2_valid_q <= 1'b0;
            t2_sign_q  <= 1'b0;
            t2_y_q     <= '0;
            t2_addr_q  <= '0;
        end else begin
            t2_valid_q <= t1_valid_q;
            t2_sign_q  <= t1_sign_q;
            t2_y_q     <= y_d;
            t2_addr_q  <= t1_addr_q;
        end
    end

    // T3 sign restore: tanh is odd, so negate the magnitude for negative x.
    always_comb begin
        y_mag_d = {3'b000, t2_y_q};
    end

    // T3 register: outputs hold their last valid result between writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_o <= 1'b0;
            y_o     <= '0;
            addr_o  <= '0;
        end else begin
            valid_o <= t2_valid_q;
            if (t2_valid_q) begin
                y_o    <= t2_sign_q ? -y_mag_d : y_mag_d;
                addr_o <= t2_addr_q;
            end
        end
    end

endmodule

// File: rtl/tanh_mac_datapath.sv
// Dot-product MAC feeding a piecewise-linear tanh. One element per cycle;
// the result of a vector appears five cycles after its last element.
module tanh_mac_datapath #(
    parameter int DATA_W = tanh_pkg::DATA_W,
    parameter int FRAC_W = tanh_pkg::FRAC_W,
    parameter int ACC_W  = tanh_pkg::ACC_W,
    parameter int ADDR_W = tanh_pkg::ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0]        in_addr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     sat_flag,
    input  logic                     clear_flag
);

    localparam logic signed [ACC_W-1:0] X_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] X_MIN = ~X_MAX;
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(2 ** (FRAC_W - 1));

    logic                       p_valid_q, p_first_q, p_last_q;
    logic [ADDR_W-1:0]          p_addr_q;
    logic signed [2*DATA_W-1:0] p_prod_q;

    logic signed [ACC_W-1:0]    acc_d, acc_q;
    logic                       a_valid_q;
    logic [ADDR_W-1:0]          a_addr_q;

    logic signed [ACC_W-1:0]    x_wide_d;
    logic signed [DATA_W-1:0]   x_sat_d;
    logic                       sat_d;

    // P1: register the Q8.24 product with its sideband; a bubble carries no flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_addr_q  <= '0;
            p_prod_q  <= '0;
        end else begin
            p_valid_q <= in_valid;
            p_first_q <= in_valid & in_first;
            p_last_q  <= in_valid & in_last;
            p_addr_q  <= in_addr;
            p_prod_q  <= x_data * w_data;
        end
    end

    // Accumulate: a first element restarts the sum (dropping any partial one).
    always_comb begin
        acc_d = acc_q;
        if (p_valid_q) begin
            acc_d = p_first_q ? ACC_W'(p_prod_q) : acc_q + ACC_W'(p_prod_q);
        end
    end

    // A: accumulator plus a one-cycle valid marking a completed vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q     <= '0;
            a_valid_q <= 1'b0;
            a_addr_q  <= '0;
        end else begin
            acc_q     <= acc_d;
            a_valid_q <= p_valid_q & p_last_q;
            if (p_valid_q & p_last_q) begin
                a_addr_q <= p_addr_q;
            end
        end
    end

    // Round Q.24 to Q.12 half-up, then saturate into the DATA_W range.
    always_comb begin
        x_wide_d = (acc_q + RND) >>> FRAC_W;
        sat_d    = 1'b1;
        if (x_wide_d > X_MAX) begin
            x_sat_d = DATA_W'(X_MAX);
        end else if (x_wide_d < X_MIN) begin
            x_sat_d = DATA_W'(X_MIN);
        end else begin
            x_sat_d = x_wide_d[DATA_W-1:0];
            sat_d   = 1'b0;
        end
    end

    // Sticky saturation flag; a new saturation wins over a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (a_valid_q & sat_d) begin
            sat_flag <= 1'b1;
        end else if (clear_flag) begin
            sat_flag <= 1'b0;
        end
    end

    tanh_pwl #(
        .AW (ADDR_W)
    ) u_pwl (
        .clock   (clock),
        .reset   (reset),
        .valid_i (a_valid_q),
        .x_i     (x_sat_d),
        .addr_i  (a_addr_q),
        .valid_o (out_valid),
        .y_o     (out_data),
        .addr_o  (out_addr)
    );

endmodule

// File: tb/tb_tanh_mac_datapath.sv
// Self-checking bench: directed scenarios followed by random vectors, all
// compared cycle by cycle against an arithmetic model of the datapath.
module tb_tanh_mac_datapath;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic signed [15:0] x_data = '0, w_data = '0;
    logic [11:0]        in_addr = '0;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic [11:0]        out_addr;
    logic               sat_flag;
    logic               clear_flag = 1'b0;

    tanh_mac_datapath dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_last    (in_last),
        .x_data     (x_data),
        .w_data     (w_data),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .sat_flag   (sat_flag),
        .clear_flag (clear_flag)
    );

    always #5 clock = ~clock;

    localparam int DEPTH = 16384;

    int base_t  [8] = '{0, 1893, 3119, 3707, 3949, 4041, 4076, 4089};
    int slope_t [8] = '{3786, 2452, 1176, 484, 184, 70, 26, 8};

    int                 n_checks = 0;
    int                 n_err    = 0;
    int                 cyc      = 0;
    longint             acc_m    = 0;
    bit                 sat_m    = 1'b0;
    bit                 exp_v [DEPTH];
    logic signed [15:0] exp_d [DEPTH];
    logic [11:0]        exp_a [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // Reference tanh: piecewise linear over half-unit segments of |x|.
    function automatic int pwl_ref(input longint x);
        longint ax;
        int     y;
        ax = (x < 0) ? -x : x;
        if (ax >= 16384) y = 4093;
        else y = base_t[ax / 2048] + int'((slope_t[ax / 2048] * (ax % 2048)) / 4096);
        return (x < 0) ? -y : y;
    endfunction

    // One clock: drive inputs, update the model, then compare outputs after the edge.
    task automatic step(input bit v, input bit f, input bit l,
                        input logic signed [15:0] x, input logic signed [15:0] w,
                        input logic [11:0] a, input bit clr, input bit rst);
        longint xr;
        in_valid = v; in_first = f; in_last = l;
        x_data = x; w_data = w; in_addr = a;
        clear_flag = clr; reset = rst;
        if (rst) begin
            acc_m = 0;
            sat_m = 1'b0;
            for (int k = cyc + 1; k <= cyc + 7; k++) exp_v[k] = 1'b0;
        end else begin
            if (v) begin
                acc_m = f ? longint'(x) * longint'(w) : acc_m + longint'(x) * longint'(w);
                if (l) begin
                    xr = (acc_m + 2048) >>> 12;
                    if (xr > 32767)  begin xr = 32767;  sat_m = 1'b1; end
                    if (xr < -32768) begin xr = -32768; sat_m = 1'b1; end
                    exp_v[cyc + 5] = 1'b1;
                    exp_d[cyc + 5] = 16'(pwl_ref(xr));
                    exp_a[cyc + 5] = a;
                end
            end
            if (clr) sat_m = 1'b0;
        end
        @(posedge clock);
        #1;
        cyc++;
        check("out_valid", 32'(out_valid), 32'(exp_v[cyc]));
        if (exp_v[cyc]) begin
            check("out_data", 32'(out_data), 32'(exp_d[cyc]));
            check("out_addr", 32'(out_addr), 32'(exp_a[cyc]));
        end
    endtask

    task automatic elem(input bit f, input bit l, input logic signed [15:0] x,
                        input logic signed [15:0] w, input logic [11:0] a);
        step(1'b1, f, l, x, w, a, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 16'sd0, 16'sd0, 12'd0, 1'b0, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_addr"},  32'(out_addr),  32'd0);
        check({tag, "_sat"},   32'(sat_flag),  32'd0);
    endtask

    initial begin
        logic signed [15:0] rx, rw;
        logic [11:0]        ra;
        int                 len;
        bit                 drop;

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 12'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 12'd0, 1'b0, 1'b1);
        check_quiet("reset");
        idle(2);

        // Single elements: 1.0*1.0, -1.0*1.0, 0.
        elem(1'b1, 1'b1, 16'sd4096, 16'sd4096, 12'd5);
        idle(6);
        check("tanh_1p0", 32'(out_data), 32'(16'sd3119));
        elem(1'b1, 1'b1, -16'sd4096, 16'sd4096, 12'd6);
        idle(6);
        check("tanh_m1p0", 32'(out_data), 32'(-16'sd3119));
        elem(1'b1, 1'b1, 16'sd0, 16'sd4096, 12'd7);
        idle(6);

        // 4-element vector 0.25*0.5, then again with a bubble.
        elem(1'b1, 1'b0, 16'sd1024, 16'sd2048, 12'd1);
        elem(1'b0, 1'b0, 16'sd1024, 16'sd2048, 12'd2);
        elem(1'b0, 1'b0, 16'sd1024, 16'sd2048, 12'd3);
        elem(1'b0, 1'b1, 16'sd1024, 16'sd2048, 12'h2A5);
        idle(6);
        check("vec4", 32'(out_data), 32'(16'sd1893));
        elem(1'b1, 1'b0, 16'sd1024, 16'sd2048, 12'd1);
        elem(1'b0, 1'b0, 16'sd1024, 16'sd2048, 12'd2);
        step(1'b0, 1'b1, 1'b0, 16'sd9, 16'sd9, 12'd0, 1'b0, 1'b0);
        elem(1'b0, 1'b0, 16'sd1024, 16'sd2048, 12'd3);
        elem(1'b0, 1'b1, 16'sd1024, 16'sd2048, 12'h3C3);
        idle(6);

        // Saturation, sticky flag, clear.
        elem(1'b1, 1'b0, 16'sd32767, 16'sd32767, 12'd9);
        elem(1'b0, 1'b1, 16'sd32767, 16'sd32767, 12'd10);
        idle(6);
        check("sat_set", 32'(sat_flag), 32'd1);
        check("sat_data", 32'(out_data), 32'(16'sd4093));
        step(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 12'd0, 1'b1, 1'b0);
        check("sat_clear", 32'(sat_flag), 32'd0);
        idle(1);

        // Back-to-back length-1 vectors.
        elem(1'b1, 1'b1, 16'sd2048, 16'sd4096, 12'd20);
        elem(1'b1, 1'b1, 16'sd6144, 16'sd4096, 12'd21);
        elem(1'b1, 1'b1, -16'sd20000, 16'sd4096, 12'd22);
        idle(6);
        check("b2b_last", 32'(out_data), 32'(-16'sd4093));
        check("b2b_nosat", 32'(sat_flag), 32'd0);

        // Reset two cycles after a last element (mid-vector state too).
        elem(1'b1, 1'b0, 16'sd3000, 16'sd3000, 12'd30);
        elem(1'b0, 1'b1, 16'sd3000, 16'sd3000, 12'd31);
        elem(1'b1, 1'b0, 16'sd5000, 16'sd5000, 12'd32);
        step(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 12'd0, 1'b0, 1'b1);
        idle(7);
        check_quiet("post_reset");
        elem(1'b1, 1'b1, 16'sd4096, 16'sd4096, 12'd33);
        idle(6);

        // Random vectors: varied lengths, bubbles, abandoned partial sums.
        for (int v = 0; v < 200; v++) begin
            len  = $urandom_range(1, 6);
            drop = ($urandom_range(0, 7) == 0) && (len > 1);
            ra   = 12'($urandom);
            for (int i = 0; i < len; i++) begin
                if (drop && i == len - 1) break;
                if ($urandom_range(0, 4) == 0)
                    step(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 12'($urandom), 1'b0, 1'b0);
                rx = 16'($urandom);
                rw = 16'($urandom);
                if ($urandom_range(0, 3) != 0) rx = rx >>> 3;
                if ($urandom_range(0, 3) != 0) rw = rw >>> 2;
                elem(i == 0, i == len - 1, rx, rw, (i == len - 1) ? ra : 12'($urandom));
            end
        end
        idle(7);
        check("rand_sat", 32'(sat_flag), 32'(sat_m));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
